vec_packer: RTL and testbench
=============================

VEC_PACKER -- requirements
Module: vec_packer

Interface
REQ-001 Parameter NUM_OUT, default 8: number of lanes in one packed output vector (2..16).
REQ-002 Parameter DW_DATA, default 8: width of one element in bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  in_data/in_last carry a valid element.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 in_data  input  DW_DATA  element value.
REQ-008 in_last  input  1  element ends the current vector; remaining lanes are zero-padded.
REQ-009 out_valid  output  1  out_data/out_count/out_last hold a complete vector.
REQ-010 out_ready  input  1  downstream (reduction tree) accepts the vector this cycle.
REQ-011 out_data  output  NUM_OUT*DW_DATA  packed vector; lane i occupies bits [i*DW_DATA +: DW_DATA].
REQ-012 out_count  output  $clog2(NUM_OUT+1)  number of filled lanes, 1..NUM_OUT.
REQ-013 out_last  output  1  vector was closed by in_last (1) or by filling all lanes (0).

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 in_ready SHALL equal (!out_valid || out_ready) and depend on no input-side signal.
REQ-016 Block SHALL hold an assembly register (NUM_OUT lanes), a lane counter cnt, and an output register.
REQ-017 FSM states: IDLE (cnt==0) and FILL (0<cnt<NUM_OUT); IDLE->FILL on an accepted non-closing element; FILL->IDLE on an accepted closing element.
REQ-018 The k-th accepted element of a vector (k from 0) SHALL be written to assembly lane k; cnt increments by 1.
REQ-019 An element is closing if in_last==1 or cnt==NUM_OUT-1 at acceptance.
REQ-020 On accepting a closing element, the completed vector (including that element) SHALL be loaded into the output register on the same edge; out_valid rises the following cycle (latency 1 cycle from last accept).
REQ-021 Lanes at index >= out_count in out_data SHALL be zero.
REQ-022 out_count SHALL equal cnt+1 at the closing accept; out_last SHALL equal in_last of the closing element.
REQ-023 After a closing accept, cnt SHALL be 0 and assembly lanes SHALL be zero before the next vector's first element.
REQ-024 out_valid SHALL remain high with out_data/out_count/out_last stable until the output transfer.
REQ-025 Output transfer without a same-cycle closing accept SHALL clear out_valid next cycle.
REQ-026 Simultaneous output transfer and closing accept SHALL keep out_valid high and load the new vector (no bubble).
REQ-027 in_last on the NUM_OUT-th element SHALL produce out_count=NUM_OUT, out_last=1.
REQ-028 in_last on the first element SHALL produce out_count=1, lane 0 = element, all other lanes zero.
REQ-029 With out_ready held high, sustained throughput SHALL be one element per cycle.
REQ-030 No element SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-031 On rst: out_valid=0, out_data=0, out_count=0, out_last=0, cnt=0, assembly lanes=0, FSM=IDLE.
REQ-032 in_ready SHALL be 1 during and after reset (out_valid==0).
REQ-033 rst asserted mid-vector SHALL discard the partial vector and any pending output vector; no output transfer results from it.

Verification
REQ-034 Defaults; stream 1..8, in_last=0, out_ready=1 -> one vector, lanes 0..7 = 1..8, out_count=8, out_last=0, out_valid 1 cycle after 8th accept.
REQ-035 Stream 5,6,7 with in_last on 7 -> out_data lanes = 5,6,7,0,0,0,0,0, out_count=3, out_last=1.
REQ-036 out_ready=0 while 16 elements offered back-to-back -> first vector held stable, in_ready drops after 8th accept, second vector fills after out_ready=1; both vectors intact, order preserved.
REQ-037 Continuous 24 elements, out_ready=1 -> 3 vectors, no bubble on in_ready, out_valid high on consecutive vector-complete cycles.
REQ-038 rst pulsed after 3 of 8 elements, then stream 9..16 -> single vector lanes 9..16, out_count=8; no vector containing pre-reset elements.
REQ-039 Random in_valid/out_ready (10^4 elements, random in_last) vs. scoreboard -> every element appears exactly once in correct lane, padding lanes zero.

Source files
------------

// File: rtl/vec_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vec_packer
// Description : Packs a stream of DW_DATA-bit elements into NUM_OUT-lane
//               vectors for a downstream reduction tree. A vector closes
//               when in_last is seen or all lanes are filled; unused lanes
//               are zero. A one-entry output register, with pass-through
//               ready, gives one element per cycle when out_ready is high.
// Ports       : clk, rst                   - clock, sync active-high reset
//               in_valid/in_ready          - input element handshake
//               in_data, in_last           - element value, vector close
//               out_valid/out_ready        - output vector handshake
//               out_data                   - lane i at [i*DW_DATA +: DW_DATA]
//               out_count                  - filled lanes (1..NUM_OUT)
//               out_last                   - 1: closed by in_last, 0: full
// Revision    : 1.0 - initial release
// ============================================================================
module vec_packer #(
    parameter int NUM_OUT = 8,
    parameter int DW_DATA = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW_DATA-1:0]            in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_OUT*DW_DATA-1:0]    out_data,
    output logic [$clog2(NUM_OUT+1)-1:0]  out_count,
    output logic                          out_last
);

    localparam int              c_CW       = $clog2(NUM_OUT + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(NUM_OUT - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_FILL = 1'b1;

    logic [0:0]                 r_state;
    logic [c_CW-1:0]            r_cnt;
    logic [NUM_OUT*DW_DATA-1:0] r_asm;
    logic [NUM_OUT*DW_DATA-1:0] r_out_data;
    logic [c_CW-1:0]            r_out_count;
    logic                       r_out_valid;
    logic                       r_out_last;

    logic                       w_in_fire;
    logic                       w_out_fire;
    logic                       w_closing;
    logic [c_CW-1:0]            w_lane_sel;
    logic [NUM_OUT*DW_DATA-1:0] w_asm_next;

    // Ready depends only on the output register, so there is no
    // combinational path from in_valid back to in_ready.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_closing  = in_last || (r_cnt == c_CNT_LAST);

    // In IDLE the counter is zero, so the element always lands in lane 0.
    assign w_lane_sel = (r_state == c_ST_IDLE) ? '0 : r_cnt;

    // Assembly contents including the element being offered this cycle.
    // Lanes above the write lane are already zero, which provides the
    // padding for short vectors without extra masking.
    always_comb begin
        w_asm_next = r_asm;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_lane_sel == c_CW'(i)) begin
                w_asm_next[i*DW_DATA +: DW_DATA] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_asm       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_closing) begin
                    // Hand the finished vector to the output register and
                    // clear the assembly for the next vector.
                    r_out_data  <= w_asm_next;
                    r_out_count <= r_cnt + c_CW'(1);
                    r_out_last  <= in_last;
                    r_asm       <= '0;
                    r_cnt       <= '0;
                    r_state     <= c_ST_IDLE;
                end else begin
                    r_asm       <= w_asm_next;
                    r_cnt       <= r_cnt + c_CW'(1);
                    r_state     <= c_ST_FILL;
                end
            end

            // A closing accept may coincide with draining the old vector;
            // the new one takes its place with no idle cycle.
            if (w_in_fire && w_closing) begin
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_vec_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vec_packer
// Description : Self-checking bench for vec_packer. A reference model
//               assembles accepted elements and queues expected vectors;
//               the output monitor pops and compares on every output
//               transfer. Directed table cases, multi-cycle back-pressure
//               and reset sequences, then a long random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_packer;

    localparam int NUM_OUT = 8;
    localparam int DW      = 8;
    localparam int CW      = $clog2(NUM_OUT + 1);
    localparam int VW      = NUM_OUT * DW;
    localparam int N_RAND  = 10000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_last;

    vec_packer #(.NUM_OUT(NUM_OUT), .DW_DATA(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] data;
        int            count;
        bit            last;
    } vec_t;

    typedef struct {
        int            n;
        bit            last;
        logic [DW-1:0] base;
        int            exp_count;
        bit            exp_last;
    } tcase_t;

    vec_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;

    logic [VW-1:0] m_asm = '0;
    int            m_cnt = 0;
    bit            m_pend_close = 0;
    bit            hold_v = 0;
    logic [VW-1:0] hold_data;
    logic [CW-1:0] hold_count;
    logic          hold_last;
    int            vec_seen = 0;
    int            got_count = 0;
    bit            got_last = 0;
    logic [VW-1:0] got_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor and reference model, sampled on the falling edge.
    always @(negedge clk) begin
        vec_t e;
        vec_t n;
        if (rst) begin
            sb_q.delete();
            m_asm        = '0;
            m_cnt        = 0;
            m_pend_close = 0;
            hold_v       = 0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (m_pend_close) check("close_latency", out_valid, 1'b1);
            m_pend_close = 0;
            if (hold_v) begin
                check("hold_valid", out_valid, 1'b1);
                if (out_valid) begin
                    check("hold_data", out_data, hold_data);
                    check("hold_count", out_count, hold_count);
                    check("hold_last", out_last, hold_last);
                end
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_vector", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("vec_data", out_data, e.data);
                    check("vec_count", out_count, e.count);
                    check("vec_last", out_last, e.last);
                end
                vec_seen++;
                got_count = int'(out_count);
                got_last  = out_last;
                got_data  = out_data;
            end
            hold_v     = out_valid && !out_ready;
            hold_data  = out_data;
            hold_count = out_count;
            hold_last  = out_last;
            if (in_valid && in_ready) begin
                m_asm[m_cnt*DW +: DW] = in_data;
                m_cnt++;
                if (in_last || m_cnt == NUM_OUT) begin
                    n.data  = m_asm;
                    n.count = m_cnt;
                    n.last  = in_last;
                    sb_q.push_back(n);
                    m_asm        = '0;
                    m_cnt        = 0;
                    m_pend_close = 1;
                end
            end
        end
    end

    // Offer one element and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [DW-1:0] d, input bit l, output int stalls);
        bit done;
        done     = 0;
        stalls   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
            if (!done && stalls > 200) begin
                check("send_timeout", 1'b1, 1'b0);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_vecs(input int target, input string name);
        int b;
        b = 0;
        while (vec_seen < target && b < 1000) begin
            @(posedge clk);
            b++;
        end
        #1;
        check(name, vec_seen, target);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tcase_t        tbl[5];
        int            s;
        int            total;
        int            vs;
        logic [VW-1:0] exp_vec;
        int            sent;
        int            cyc;
        bit            acc;
        int            b;

        tbl[0] = '{n: 8, last: 1'b0, base: 8'h01, exp_count: 8, exp_last: 1'b0};
        tbl[1] = '{n: 3, last: 1'b1, base: 8'h05, exp_count: 3, exp_last: 1'b1};
        tbl[2] = '{n: 1, last: 1'b1, base: 8'hAA, exp_count: 1, exp_last: 1'b1};
        tbl[3] = '{n: 8, last: 1'b1, base: 8'h20, exp_count: 8, exp_last: 1'b1};
        tbl[4] = '{n: 5, last: 1'b1, base: 8'h40, exp_count: 5, exp_last: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_count", out_count, '0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: length, closing reason, lane contents.
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            vs = vec_seen;
            for (int j = 0; j < tbl[t].n; j++) begin
                send(tbl[t].base + DW'(j), tbl[t].last && (j == tbl[t].n - 1), s);
            end
            wait_vecs(vs + 1, "tbl_vec_done");
            check("tbl_count", got_count, tbl[t].exp_count);
            check("tbl_last", got_last, tbl[t].exp_last);
            check("tbl_lane0", got_data[DW-1:0], tbl[t].base);
        end

        // Back-pressure: 16 elements against a stalled output.
        out_ready = 1'b0;
        vs = vec_seen;
        fork
            begin
                for (int j = 0; j < 16; j++) send(8'h30 + DW'(j), 1'b0, s);
            end
            begin
                repeat (12) @(negedge clk);
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_out_valid_high", out_valid, 1'b1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_vecs(vs + 2, "bp_two_vectors");
        for (int j = 0; j < NUM_OUT; j++) exp_vec[j*DW +: DW] = 8'h38 + DW'(j);
        check("bp_second_vec", got_data, exp_vec);

        // Continuous stream: three vectors, input never stalls.
        vs = vec_seen;
        total = 0;
        for (int j = 0; j < 24; j++) begin
            send(8'h60 + DW'(j), 1'b0, s);
            total += s;
        end
        check("stream_no_bubble", total, 0);
        wait_vecs(vs + 3, "stream_three_vectors");

        // Reset discards a pending output vector.
        out_ready = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) send(8'h80 + DW'(j), 1'b0, s);
        pulse_reset();
        @(negedge clk);
        check("rst_drop_pending", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Reset discards a partial vector; next vector is clean.
        out_ready = 1'b1;
        vs = vec_seen;
        for (int j = 0; j < 3; j++) send(8'h90 + DW'(j), 1'b0, s);
        pulse_reset();
        for (int j = 0; j < NUM_OUT; j++) send(DW'(9 + j), 1'b0, s);
        wait_vecs(vs + 1, "rst_one_vector");
        for (int j = 0; j < NUM_OUT; j++) exp_vec[j*DW +: DW] = DW'(9 + j);
        check("rst_clean_vec", got_data, exp_vec);
        check("rst_clean_count", got_count, NUM_OUT);
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_extra_vec", vec_seen, vs + 1);

        // Random valid/ready/last against the scoreboard.
        sent = 0;
        cyc  = 0;
        acc  = 0;
        while (sent < N_RAND && cyc < 60000) begin
            if (acc) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
                in_last  = ($urandom_range(0, 5) == 0);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_sent", sent, N_RAND);
        out_ready = 1'b1;
        send(8'hFF, 1'b1, s);
        b = 0;
        while (sb_q.size() != 0 && b < 100) begin
            @(posedge clk);
            b++;
        end
        #1;
        check("rand_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
